// File: rtl/cordic_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : cordic_mult_sched
// Description : Sequences one Q16.16 CORDIC linear-mode multiply: z-range
//               normalisation, core multiply, then saturating left rescale.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_mult_sched #(
    parameter int WIDTH     = 32,
    parameter int MAX_SHIFT = 15,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             norm_en,
    output logic [WIDTH-1:0] norm_z,
    input  logic [WIDTH-1:0] norm_z_out,
    input  logic [WIDTH-1:0] norm_count,
    input  logic             norm_done,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_z,
    input  logic [WIDTH-1:0] core_y,
    input  logic             core_done,
    output logic [WIDTH-1:0] y_out,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    localparam int               TW          = $clog2(TIMEOUT + 2);
    localparam logic [WIDTH-1:0] c_K_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_MAX_SHIFT = WIDTH'(MAX_SHIFT);
    localparam logic [TW-1:0]    c_TIMEOUT   = TW'(TIMEOUT);
    localparam logic [TW-1:0]    c_TMO_ONE   = TW'(1);
    localparam logic [WIDTH-1:0] c_SAT_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_CORE  = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state_q,      w_state_d;
    logic [WIDTH-1:0] r_norm_z_q,     w_norm_z_d;
    logic [WIDTH-1:0] r_core_x_q,     w_core_x_d;
    logic [WIDTH-1:0] r_core_z_q,     w_core_z_d;
    logic [WIDTH-1:0] r_k_q,          w_k_d;
    logic [WIDTH-1:0] r_acc_q,        w_acc_d;
    logic [TW-1:0]    r_tmo_q,        w_tmo_d;
    logic [WIDTH-1:0] r_y_out_q,      w_y_out_d;
    logic             r_norm_en_q,    w_norm_en_d;
    logic             r_core_start_q, w_core_start_d;
    logic             r_busy_q,       w_busy_d;
    logic             r_done_q,       w_done_d;
    logic             r_ovf_q,        w_ovf_d;
    logic             r_err_q,        w_err_d;
    logic [WIDTH-1:0] w_sat_val;

    // Saturation direction follows the true product sign, not the core result.
    assign w_sat_val = (r_core_x_q[WIDTH-1] ^ r_norm_z_q[WIDTH-1]) ? c_SAT_NEG : c_SAT_POS;

    always_comb begin
        w_state_d      = r_state_q;
        w_norm_z_d     = r_norm_z_q;
        w_core_x_d     = r_core_x_q;
        w_core_z_d     = r_core_z_q;
        w_k_d          = r_k_q;
        w_acc_d        = r_acc_q;
        w_tmo_d        = r_tmo_q;
        w_y_out_d      = r_y_out_q;
        w_norm_en_d    = 1'b0;
        w_core_start_d = 1'b0;
        w_done_d       = 1'b0;
        w_ovf_d        = r_ovf_q;
        w_err_d        = r_err_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_core_x_d  = x_in;
                    w_norm_z_d  = z_in;
                    w_norm_en_d = 1'b1;
                    w_k_d       = '0;
                    w_tmo_d     = '0;
                    w_state_d   = S_NORM;
                end
            end
            S_NORM: begin
                if (norm_done) begin
                    w_core_z_d     = norm_z_out;
                    w_k_d          = norm_count;
                    w_core_start_d = 1'b1;
                    w_tmo_d        = '0;
                    w_state_d      = S_CORE;
                end else if (r_tmo_q == c_TIMEOUT) begin
                    w_y_out_d = '0;
                    w_ovf_d   = 1'b0;
                    w_err_d   = 1'b1;
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end else begin
                    w_tmo_d = r_tmo_q + c_TMO_ONE;
                end
            end
            S_CORE: begin
                if (core_done) begin
                    w_acc_d = core_y;
                    if (r_k_q > c_MAX_SHIFT && core_y != '0) begin
                        w_y_out_d = w_sat_val;
                        w_ovf_d   = 1'b1;
                        w_err_d   = 1'b0;
                        w_done_d  = 1'b1;
                        w_state_d = S_DONE;
                    end else if (r_k_q == '0 || r_k_q > c_MAX_SHIFT) begin
                        // Nothing to rescale: k is zero, or the result is zero.
                        w_y_out_d = core_y;
                        w_ovf_d   = 1'b0;
                        w_err_d   = 1'b0;
                        w_done_d  = 1'b1;
                        w_state_d = S_DONE;
                    end else begin
                        w_state_d = S_SCALE;
                    end
                end else if (r_tmo_q == c_TIMEOUT) begin
                    w_y_out_d = '0;
                    w_ovf_d   = 1'b0;
                    w_err_d   = 1'b1;
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end else begin
                    w_tmo_d = r_tmo_q + c_TMO_ONE;
                end
            end
            S_SCALE: begin
                if (r_acc_q[WIDTH-1] != r_acc_q[WIDTH-2]) begin
                    w_y_out_d = w_sat_val;
                    w_ovf_d   = 1'b1;
                    w_err_d   = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end else begin
                    w_acc_d = r_acc_q << 1;
                    w_k_d   = r_k_q - c_K_ONE;
                    if (r_k_q <= c_K_ONE) begin
                        w_y_out_d = r_acc_q << 1;
                        w_ovf_d   = 1'b0;
                        w_err_d   = 1'b0;
                        w_done_d  = 1'b1;
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_norm_z_q     <= '0;
            r_core_x_q     <= '0;
            r_core_z_q     <= '0;
            r_k_q          <= '0;
            r_acc_q        <= '0;
            r_tmo_q        <= '0;
            r_y_out_q      <= '0;
            r_norm_en_q    <= 1'b0;
            r_core_start_q <= 1'b0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
            r_ovf_q        <= 1'b0;
            r_err_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_norm_z_q     <= w_norm_z_d;
            r_core_x_q     <= w_core_x_d;
            r_core_z_q     <= w_core_z_d;
            r_k_q          <= w_k_d;
            r_acc_q        <= w_acc_d;
            r_tmo_q        <= w_tmo_d;
            r_y_out_q      <= w_y_out_d;
            r_norm_en_q    <= w_norm_en_d;
            r_core_start_q <= w_core_start_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
            r_ovf_q        <= w_ovf_d;
            r_err_q        <= w_err_d;
        end
    end

    assign norm_en    = r_norm_en_q;
    assign norm_z     = r_norm_z_q;
    assign core_start = r_core_start_q;
    assign core_x     = r_core_x_q;
    assign core_z     = r_core_z_q;
    assign y_out      = r_y_out_q;
    assign busy       = r_busy_q;
    assign done       = r_done_q;
    assign ovf        = r_ovf_q;
    assign err        = r_err_q;

endmodule
`default_nettype wire
